// File: rtl/matinv_pkg.sv
// Shared definitions for the fraction-free Gauss-Jordan matrix inverse block.
// Holds the controller state encoding and the default matrix order / element
// width used by matrix_inverse_seq.
package matinv_pkg;

    localparam int N_DEF = 5;
    localparam int W_DEF = 32;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SEARCH,
        ST_SWAP,
        ST_ELIM,
        ST_OUT
    } state_t;

endpackage

// File: rtl/matinv_row_update.sv
// Cross-multiply-subtract of one matrix row against the pivot row, applied to
// both the A half and the augmented (inverse) half. Purely combinational.
//
// Ports:
//   pivot      A[k][k]
//   factor     A[i][k]
//   row_k_a    pivot row of A          row_i_a    target row of A
//   row_k_inv  pivot row of I          row_i_inv  target row of I
//   new_a      updated target row of A
//   new_inv    updated target row of I
// Results wrap modulo 2^W; there is no saturation.
module matinv_row_update #(
    parameter int N = 5,
    parameter int W = 32
) (
    input  logic [W-1:0]        pivot,
    input  logic [W-1:0]        factor,
    input  logic [N-1:0][W-1:0] row_k_a,
    input  logic [N-1:0][W-1:0] row_i_a,
    input  logic [N-1:0][W-1:0] row_k_inv,
    input  logic [N-1:0][W-1:0] row_i_inv,
    output logic [N-1:0][W-1:0] new_a,
    output logic [N-1:0][W-1:0] new_inv
);

    always_comb begin
        new_a   = '0;
        new_inv = '0;
        for (int j = 0; j < N; j++) begin
            new_a[j]   = row_i_a[j]   * pivot - row_k_a[j]   * factor;
            new_inv[j] = row_i_inv[j] * pivot - row_k_inv[j] * factor;
        end
    end

endmodule

// File: rtl/matrix_inverse_seq.sv
// Sequential fraction-free Gauss-Jordan inverter. Streams in an N x N matrix
// row-major, eliminates one row per cycle, then streams out the unnormalised
// inverse numerators; the true inverse is out_data / out_pivot per row.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input element handshake, in_data row-major A elements
//   out_valid/ready output element handshake
//   out_data        inverse numerator I[r][c]
//   out_pivot       final diagonal A[r][r] of the current output row
//   out_last        final output beat
//   singular        no non-zero pivot found (valid with out_valid)
//   busy            low only while waiting for the first input beat
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | accept N*N input beats; identity written into I on first beat
// ST_SEARCH | scan rows r >= k for a non-zero A[r][k], one row per cycle
// ST_SWAP   | exchange rows k and ps of A and I (always one cycle)
// ST_ELIM   | update one row i != k per cycle, ascending
// ST_OUT    | stream I row-major with per-row pivot
module matrix_inverse_seq
    import matinv_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [W-1:0] out_pivot,
    output logic         out_last,
    output logic         singular,
    output logic         busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_t state, state_next;

    logic [W-1:0] a_mat [N][N];
    logic [W-1:0] i_mat [N][N];

    logic [IW-1:0] k, r, ps, ei;
    logic [IW-1:0] row_cnt, col_cnt;

    logic load_fire, load_first, load_done;
    logic out_fire, out_done, cnt_last;
    logic hit, ei_last;
    logic [IW-1:0] ei_inc, ei_end;

    logic [N-1:0][W-1:0] row_k_a, row_i_a, row_k_inv, row_i_inv;
    logic [N-1:0][W-1:0] new_a, new_inv;

    assign cnt_last   = (row_cnt == LAST) && (col_cnt == LAST);
    assign load_fire  = (state == ST_LOAD) && in_valid;
    assign load_first = load_fire && (row_cnt == '0) && (col_cnt == '0);
    assign load_done  = load_fire && cnt_last;
    assign out_fire   = (state == ST_OUT) && out_ready;
    assign out_done   = out_fire && cnt_last;
    assign hit        = a_mat[r][k] != '0;
    assign ei_inc     = ei + ONE;
    // The last row to eliminate is N-1, unless k itself is N-1.
    assign ei_end     = (k == LAST) ? (LAST - ONE) : LAST;
    assign ei_last    = (ei == ei_end);

    // Lane operands come straight from the registers, so every lane sees
    // pre-update values for the cycle.
    always_comb begin
        row_k_a   = '0;
        row_i_a   = '0;
        row_k_inv = '0;
        row_i_inv = '0;
        for (int j = 0; j < N; j++) begin
            row_k_a[j]   = a_mat[k][j];
            row_i_a[j]   = a_mat[ei][j];
            row_k_inv[j] = i_mat[k][j];
            row_i_inv[j] = i_mat[ei][j];
        end
    end

    matinv_row_update #(.N(N), .W(W)) u_row_update (
        .pivot     (a_mat[k][k]),
        .factor    (a_mat[ei][k]),
        .row_k_a   (row_k_a),
        .row_i_a   (row_i_a),
        .row_k_inv (row_k_inv),
        .row_i_inv (row_i_inv),
        .new_a     (new_a),
        .new_inv   (new_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:   if (load_done) state_next = ST_SEARCH;
            ST_SEARCH: begin
                if (hit)              state_next = ST_SWAP;
                else if (r == LAST)   state_next = ST_OUT;
            end
            ST_SWAP:   state_next = ST_ELIM;
            ST_ELIM:   if (ei_last) state_next = (k == LAST) ? ST_OUT : ST_SEARCH;
            ST_OUT:    if (out_done) state_next = ST_LOAD;
            default:   state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            r        <= '0;
            ps       <= '0;
            ei       <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            singular <= 1'b0;
        end else begin
            case (state)
                ST_LOAD, ST_OUT: begin
                    if (load_fire || out_fire) begin
                        if (col_cnt == LAST) begin
                            col_cnt <= '0;
                            row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + ONE;
                        end else begin
                            col_cnt <= col_cnt + ONE;
                        end
                    end
                    if (load_done || out_done) begin
                        k <= '0;
                        r <= '0;
                    end
                    if (out_done) singular <= 1'b0;
                end
                ST_SEARCH: begin
                    if (hit) begin
                        ps <= r;
                        ei <= (k == '0) ? ONE : '0;
                    end else if (r == LAST) begin
                        singular <= 1'b1;
                    end else begin
                        r <= r + ONE;
                    end
                end
                ST_ELIM: begin
                    if (ei_last) begin
                        k <= k + ONE;
                        r <= k + ONE;
                    end else begin
                        ei <= (ei_inc == k) ? ei_inc + ONE : ei_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Matrix storage carries no reset; a fresh load overwrites all of A and
    // re-seeds I on its first beat.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            if (load_first) begin
                for (int ri = 0; ri < N; ri++)
                    for (int ci = 0; ci < N; ci++)
                        i_mat[ri][ci] <= (ri == ci) ? W'(1) : '0;
            end
            a_mat[row_cnt][col_cnt] <= in_data;
        end else if (state == ST_SWAP) begin
            for (int j = 0; j < N; j++) begin
                a_mat[k][j]  <= a_mat[ps][j];
                a_mat[ps][j] <= a_mat[k][j];
                i_mat[k][j]  <= i_mat[ps][j];
                i_mat[ps][j] <= i_mat[k][j];
            end
        end else if (state == ST_ELIM) begin
            for (int j = 0; j < N; j++) begin
                a_mat[ei][j] <= new_a[j];
                i_mat[ei][j] <= new_inv[j];
            end
        end
    end

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_OUT);
    assign out_data  = out_valid ? i_mat[row_cnt][col_cnt] : '0;
    assign out_pivot = out_valid ? a_mat[row_cnt][row_cnt] : '0;
    assign out_last  = out_valid && cnt_last;
    assign busy      = !((state == ST_LOAD) && (row_cnt == '0) && (col_cnt == '0));

endmodule
